mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have these ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  16  fetch address; stable while if_req
- if_rdata  out  16  fetch read data; valid when if_done
- if_done  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held until dm_done
- dm_wr  in  1  1 = store, 0 = load; stable while dm_req
- dm_addr  in  16  data address
- dm_wdata  in  16  store data
- dm_rdata  out  16  load data; valid when dm_done
- dm_done  out  1  one-cycle data completion pulse
- halt  in  1  processor HALT decoded
- halted  out  1  arbiter has quiesced
- mem_req  out  1  one-cycle request to the shared memory
- mem_wr  out  1  write enable qualifying mem_req
- mem_addr  out  16  registered address
- mem_wdata  out  16  registered write data
- mem_rdata  in  16  memory read data; valid with mem_done
- mem_done  in  1  memory completion; arrives at least 1 cycle after mem_req

Function
REQ-002 FSM states SHALL be IDLE, FETCH, DATA and HALTED, with one memory transaction outstanding at most.
REQ-003 In IDLE with halt=1, the FSM SHALL go to HALTED and ignore all requests.
REQ-004 In IDLE with halt=0, a grant decision SHALL be made at each clock edge:
- dm_req only -> DATA
- if_req only -> FETCH
- both -> DATA, unless skip_cnt==3, then FETCH
REQ-005 skip_cnt (2-bit) SHALL increment, saturating at 3, on each DATA grant made while if_req=1.
REQ-006 skip_cnt SHALL clear to 0 on every FETCH grant.
REQ-007 On the grant edge, mem_addr, mem_wdata and mem_wr SHALL be registered from the winner.
- FETCH: mem_wr=0 and mem_wdata=0.
REQ-008 mem_req SHALL be 1 for exactly the first cycle in FETCH or DATA and 0 in every other cycle.
REQ-009 mem_addr, mem_wdata and mem_wr SHALL hold constant until the next grant.
REQ-010 In FETCH or DATA, the edge that samples mem_done=1 SHALL do all of the following:
- register mem_rdata into the winner's rdata output (store: dm_rdata unchanged)
- pulse the winner's done for exactly the next cycle
- return to IDLE
REQ-011 if_rdata and dm_rdata SHALL hold their value until their next completion.
REQ-012 Latency: a request first seen in IDLE at edge N with a memory delay of k cycles SHALL produce done high in cycle N+k+1; minimum k=1 gives N+2.
REQ-013 In the cycle a requester's done is high, its req SHALL be treated as the completed request and not granted; a still-high req is eligible from the next cycle.
REQ-014 mem_done sampled in IDLE or HALTED SHALL be ignored, with no done pulse and no state change.
REQ-015 halt asserted during FETCH or DATA SHALL not abort the transaction; the FSM SHALL complete per REQ-010, then go to HALTED instead of IDLE.
REQ-016 HALTED SHALL persist until rst; halted=1 only in HALTED.
REQ-017 A request arriving in the same cycle as mem_done SHALL wait for IDLE; no grant is made from FETCH or DATA.

Reset
REQ-018 rst=1 at a clock edge SHALL, from any state including mid-transaction, force all of the following:
- state IDLE, skip_cnt 0
- mem_req, mem_wr, if_done, dm_done, halted = 0
- mem_addr, mem_wdata, if_rdata, dm_rdata = 0x0000
REQ-019 A mem_done belonging to a transaction cut off by reset SHALL be ignored per REQ-014.

Verification
REQ-020 Single fetch: if_req=1, if_addr=0x0040, mem_done 2 cycles after mem_req with mem_rdata=0xA5C3 -> mem_req pulsed once with mem_addr=0x0040 and mem_wr=0; if_done one cycle with if_rdata=0xA5C3.
REQ-021 Simultaneous requests: if_req and dm_req (load, 0x1000) both rise together -> DATA granted first with mem_addr=0x1000; fetch granted after dm_done.
REQ-022 Starvation: if_req held while dm_req is re-asserted back-to-back -> the 4th grant is FETCH and skip_cnt returns to 0.
REQ-023 Store: dm_req=1, dm_wr=1, dm_addr=0x0200, dm_wdata=0x1234 -> mem_wr=1, mem_wdata=0x1234, dm_done pulses, dm_rdata unchanged.
REQ-024 Halt mid-DATA: halt=1 one cycle after the DATA grant -> transaction completes, dm_done pulses, then halted=1; a subsequent if_req produces no mem_req.
REQ-025 Reset mid-FETCH: rst=1 for one cycle after mem_req, then a stale mem_done=1 arrives -> all outputs 0, no if_done pulse, state IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle between the shared-memory arbiter, its two requesters
// (instruction fetch and data access) and the memory it fronts.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        halt;
  logic        halted;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;

  // arbiter view
  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt,
           mem_rdata, mem_done,
    output if_rdata, if_done, dm_rdata, dm_done, halted,
           mem_req, mem_wr, mem_addr, mem_wdata
  );

  // requester / memory view
  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt,
           mem_rdata, mem_done,
    input  if_rdata, if_done, dm_rdata, dm_done, halted,
           mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-ported memory. Data accesses
// win ties, but a fetch is forced through after three consecutive data
// grants that passed over a waiting fetch.
//
// state  | meaning
// IDLE   | no transaction outstanding; grant decision on each edge
// FETCH  | fetch transaction outstanding, waiting for mem_done
// DATA   | load/store transaction outstanding, waiting for mem_done
// HALTED | quiesced after HALT; only rst leaves this state
module mem_arbiter (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, HALTED} state_t;

  state_t     state, state_nxt;
  logic [1:0] skip_cnt, skip_nxt;
  logic       halt_pend, halt_pend_nxt;
  logic       if_elig, dm_elig;
  logic       grant_if, grant_dm, complete;

  assign bus.halted = (state == HALTED);

  // state, starvation counter and remembered halt
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      skip_cnt  <= 2'd0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_nxt;
      halt_pend <= halt_pend_nxt;
    end
  end

  // grant decision and completion detection
  always_comb begin
    state_nxt     = state;
    skip_nxt      = skip_cnt;
    halt_pend_nxt = halt_pend;
    grant_if      = 1'b0;
    grant_dm      = 1'b0;
    complete      = 1'b0;
    // a requester whose done is showing is still holding its finished request
    if_elig       = bus.if_req & ~bus.if_done;
    dm_elig       = bus.dm_req & ~bus.dm_done;
    case (state)
      IDLE: begin
        if (bus.halt) begin
          state_nxt = HALTED;
        end else if (dm_elig && !(if_elig && skip_cnt == 2'd3)) begin
          grant_dm  = 1'b1;
          state_nxt = DATA;
          if (if_elig && skip_cnt != 2'd3) skip_nxt = skip_cnt + 2'd1;
        end else if (if_elig) begin
          grant_if  = 1'b1;
          state_nxt = FETCH;
          skip_nxt  = 2'd0;
        end
      end
      FETCH, DATA: begin
        if (bus.halt) halt_pend_nxt = 1'b1;
        if (bus.mem_done) begin
          complete      = 1'b1;
          state_nxt     = (bus.halt || halt_pend) ? HALTED : IDLE;
          halt_pend_nxt = 1'b0;
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // memory request, captured transaction fields, read data and done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= 16'h0000;
      bus.mem_wdata <= 16'h0000;
      bus.if_rdata  <= 16'h0000;
      bus.dm_rdata  <= 16'h0000;
      bus.if_done   <= 1'b0;
      bus.dm_done   <= 1'b0;
    end else begin
      bus.mem_req <= grant_if | grant_dm;
      bus.if_done <= complete && (state == FETCH);
      bus.dm_done <= complete && (state == DATA);
      if (grant_dm) begin
        bus.mem_addr  <= bus.dm_addr;
        bus.mem_wdata <= bus.dm_wdata;
        bus.mem_wr    <= bus.dm_wr;
      end else if (grant_if) begin
        bus.mem_addr  <= bus.if_addr;
        bus.mem_wdata <= 16'h0000;
        bus.mem_wr    <= 1'b0;
      end
      if (complete && state == FETCH) bus.if_rdata <= bus.mem_rdata;
      // mem_wr still holds the data winner's direction; stores leave dm_rdata alone
      if (complete && state == DATA && !bus.mem_wr) bus.dm_rdata <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          dm;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    int          k;
    logic [15:0] exp_wdata;
    logic [15:0] exp_if_rd;
    logic [15:0] exp_dm_rd;
    int          exp_lat;
  } vec_t;

  vec_t vt[5];

  logic [15:0] ga, gwd;
  logic        gw;
  int          glat;
  bit          ok;
  int          n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no DUT response within the cycle budget", name);
  endtask

  task automatic wait_grant(input string name, output bit found, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.mem_req !== 1'b1 && cycles < 40);
    found = (bus.mem_req === 1'b1);
    if (!found) timeout(name);
  endtask

  // waits for the grant, captures it, answers k cycles after mem_req and
  // returns at the negedge of the cycle where done should be high
  task automatic serve(input string name, input int k, input logic [15:0] rd,
                       output logic [15:0] a, output logic w, output logic [15:0] wd,
                       output int lat);
    bit f;
    int c;
    wait_grant(name, f, c);
    a = bus.mem_addr; w = bus.mem_wr; wd = bus.mem_wdata;
    lat = -1;
    if (!f) return;
    repeat (k) begin
      @(negedge clk);
      c++;
      chk({name, "_req_once"}, bus.mem_req, 1'b0);
    end
    bus.mem_done = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    c++;
    bus.mem_done = 1'b0;
    lat = c;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_mem_req"}, bus.mem_req, 1'b0);
    chk({name, "_mem_wr"}, bus.mem_wr, 1'b0);
    chk({name, "_mem_addr"}, bus.mem_addr, 16'h0);
    chk({name, "_mem_wdata"}, bus.mem_wdata, 16'h0);
    chk({name, "_if_rdata"}, bus.if_rdata, 16'h0);
    chk({name, "_dm_rdata"}, bus.dm_rdata, 16'h0);
    chk({name, "_if_done"}, bus.if_done, 1'b0);
    chk({name, "_dm_done"}, bus.dm_done, 1'b0);
    chk({name, "_halted"}, bus.halted, 1'b0);
  endtask

  // random-phase reference model state
  bit          m_busy, m_who, m_wr, just, exp_ifd, exp_dmd, pif, pdm, pdone;
  logic [15:0] m_addr, m_wd, m_ifr, m_dmr, prd;
  int          m_skip, cnt;

  initial begin
    //        dm wr addr      wdata     rd        k  exp_wdata exp_if_rd exp_dm_rd lat
    vt[0] = '{0, 0, 16'h0040, 16'h0000, 16'hA5C3, 2, 16'h0000, 16'hA5C3, 16'h0000, 4};
    vt[1] = '{1, 0, 16'h1000, 16'h5555, 16'hBEEF, 3, 16'h5555, 16'hA5C3, 16'hBEEF, 5};
    vt[2] = '{1, 1, 16'h0200, 16'h1234, 16'hDEAD, 1, 16'h1234, 16'hA5C3, 16'hBEEF, 3};
    vt[3] = '{0, 0, 16'hFFFF, 16'h0000, 16'h0001, 1, 16'h0000, 16'h0001, 16'hBEEF, 3};
    vt[4] = '{1, 1, 16'h0000, 16'hFFFF, 16'h7777, 4, 16'hFFFF, 16'h0001, 16'hBEEF, 6};

    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_wr = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.halt = 0;
    bus.mem_rdata = 0; bus.mem_done = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    // directed single transactions
    foreach (vt[i]) begin
      if (vt[i].dm) begin
        bus.dm_req = 1; bus.dm_wr = vt[i].wr; bus.dm_addr = vt[i].addr; bus.dm_wdata = vt[i].wdata;
      end else begin
        bus.if_req = 1; bus.if_addr = vt[i].addr;
      end
      serve($sformatf("vec%0d", i), vt[i].k, vt[i].rd, ga, gw, gwd, glat);
      chk($sformatf("vec%0d_addr", i), ga, vt[i].addr);
      chk($sformatf("vec%0d_wr", i), gw, vt[i].wr);
      chk($sformatf("vec%0d_wdata", i), gwd, vt[i].exp_wdata);
      chk($sformatf("vec%0d_latency", i), glat, vt[i].exp_lat);
      chk($sformatf("vec%0d_if_done", i), bus.if_done, !vt[i].dm);
      chk($sformatf("vec%0d_dm_done", i), bus.dm_done, vt[i].dm);
      chk($sformatf("vec%0d_if_rdata", i), bus.if_rdata, vt[i].exp_if_rd);
      chk($sformatf("vec%0d_dm_rdata", i), bus.dm_rdata, vt[i].exp_dm_rd);
      bus.if_req = 0; bus.dm_req = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {bus.if_done, bus.dm_done}, 2'b00);
      chk($sformatf("vec%0d_no_regrant", i), bus.mem_req, 1'b0);
    end

    // simultaneous requests: data first, then the fetch
    bus.if_req = 1; bus.if_addr = 16'h3000;
    bus.dm_req = 1; bus.dm_wr = 0; bus.dm_addr = 16'h1000;
    serve("sim_data", 1, 16'h1111, ga, gw, gwd, glat);
    chk("sim_first_addr", ga, 16'h1000);
    chk("sim_first_dm_done", bus.dm_done, 1'b1);
    chk("sim_first_if_done", bus.if_done, 1'b0);
    chk("sim_first_rdata", bus.dm_rdata, 16'h1111);
    bus.dm_req = 0;
    serve("sim_fetch", 1, 16'h2222, ga, gw, gwd, glat);
    chk("sim_second_addr", ga, 16'h3000);
    chk("sim_second_wr", gw, 1'b0);
    chk("sim_second_if_done", bus.if_done, 1'b1);
    chk("sim_second_rdata", bus.if_rdata, 16'h2222);
    bus.if_req = 0;
    @(negedge clk);

    // starvation: the fetch requester stands down only during each data
    // done cycle so the idle edge there cannot hand it the grant, letting
    // three contested data grants accumulate
    for (int i = 0; i < 3; i++) begin
      bus.if_req = 1; bus.if_addr = 16'h4000;
      bus.dm_req = 1; bus.dm_wr = 0; bus.dm_addr = 16'h5000 + 16'(i);
      serve("starve_data", 1, 16'h0, ga, gw, gwd, glat);
      chk($sformatf("starve_grant%0d_addr", i), ga, 16'h5000 + 16'(i));
      bus.if_req = 0; bus.dm_req = 0;
      @(negedge clk);
    end
    bus.if_req = 1; bus.dm_req = 1; bus.dm_addr = 16'h5003;
    serve("starve_fetch", 1, 16'h6666, ga, gw, gwd, glat);
    chk("starve_grant3_addr", ga, 16'h4000);
    chk("starve_grant3_if_done", bus.if_done, 1'b1);
    bus.if_req = 0; bus.dm_req = 0;
    @(negedge clk);
    bus.if_req = 1; bus.dm_req = 1;
    serve("starve_after", 1, 16'h0, ga, gw, gwd, glat);
    chk("starve_skip_cleared_addr", ga, 16'h5003);
    bus.dm_req = 0;
    serve("starve_tail", 1, 16'h0, ga, gw, gwd, glat);
    bus.if_req = 0;
    @(negedge clk);

    // halt one cycle after a data grant
    bus.dm_req = 1; bus.dm_wr = 0; bus.dm_addr = 16'h0600;
    wait_grant("halt_grant", ok, n);
    bus.halt = 1;
    @(negedge clk);
    chk("halt_not_yet", bus.halted, 1'b0);
    bus.mem_done = 1; bus.mem_rdata = 16'h0BAD;
    @(negedge clk);
    bus.mem_done = 0;
    chk("halt_dm_done", bus.dm_done, 1'b1);
    chk("halt_dm_rdata", bus.dm_rdata, 16'h0BAD);
    chk("halt_halted", bus.halted, 1'b1);
    bus.dm_req = 0; bus.if_req = 1; bus.if_addr = 16'h0700;
    for (int i = 0; i < 6; i++) begin
      bus.mem_done = (i == 2);
      @(negedge clk);
      chk("halted_no_req", bus.mem_req, 1'b0);
      chk("halted_no_done", {bus.if_done, bus.dm_done}, 2'b00);
      chk("halted_stays", bus.halted, 1'b1);
    end
    bus.if_req = 0; bus.halt = 0; bus.mem_done = 0;

    // reset mid-fetch, then a stale completion
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_all_zero("reset_from_halted");
    bus.if_req = 1; bus.if_addr = 16'h0ABC;
    wait_grant("rst_grant", ok, n);
    chk("rst_grant_addr", bus.mem_addr, 16'h0ABC);
    rst = 1;
    @(negedge clk);
    rst = 0; bus.if_req = 0;
    check_all_zero("rst_mid");
    bus.mem_done = 1; bus.mem_rdata = 16'h9999;
    @(negedge clk);
    bus.mem_done = 0;
    check_all_zero("stale_done");
    bus.dm_req = 1; bus.dm_wr = 0; bus.dm_addr = 16'h0777;
    serve("after_rst", 1, 16'h4444, ga, gw, gwd, glat);
    chk("after_rst_addr", ga, 16'h0777);
    chk("after_rst_latency", glat, 3);
    chk("after_rst_dm_done", bus.dm_done, 1'b1);
    chk("after_rst_if_rdata", bus.if_rdata, 16'h0);
    bus.dm_req = 0;

    // randomized traffic against the transaction model
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_busy = 0; m_who = 0; m_wr = 0; m_addr = 0; m_wd = 0; m_ifr = 0; m_dmr = 0;
    m_skip = 0; cnt = 0; exp_ifd = 0; exp_dmd = 0;
    for (int c = 0; c < 3000; c++) begin
      pif = bus.if_req && !exp_ifd;
      pdm = bus.dm_req && !exp_dmd;
      pdone = bus.mem_done;
      prd = bus.mem_rdata;
      @(negedge clk);
      just = 0; exp_ifd = 0; exp_dmd = 0;
      if (!m_busy) begin
        if (pdm && !(pif && m_skip == 3)) begin
          m_busy = 1; m_who = 1; just = 1;
          m_addr = bus.dm_addr; m_wr = bus.dm_wr; m_wd = bus.dm_wdata;
          if (pif) m_skip = (m_skip == 3) ? 3 : m_skip + 1;
        end else if (pif) begin
          m_busy = 1; m_who = 0; just = 1;
          m_addr = bus.if_addr; m_wr = 0; m_wd = 0;
          m_skip = 0;
        end
      end else if (pdone) begin
        m_busy = 0;
        if (m_who) begin
          exp_dmd = 1;
          if (!m_wr) m_dmr = prd;
        end else begin
          exp_ifd = 1;
          m_ifr = prd;
        end
      end
      chk("rnd_mem_req", bus.mem_req, just);
      chk("rnd_mem_addr", bus.mem_addr, m_addr);
      chk("rnd_mem_wr", bus.mem_wr, m_wr);
      chk("rnd_mem_wdata", bus.mem_wdata, m_wd);
      chk("rnd_if_done", bus.if_done, exp_ifd);
      chk("rnd_dm_done", bus.dm_done, exp_dmd);
      chk("rnd_if_rdata", bus.if_rdata, m_ifr);
      chk("rnd_dm_rdata", bus.dm_rdata, m_dmr);
      chk("rnd_halted", bus.halted, 1'b0);

      if (exp_ifd) bus.if_req = 0;
      else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1; bus.if_addr = 16'($urandom);
      end
      if (exp_dmd) bus.dm_req = 0;
      else if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
        bus.dm_req = 1; bus.dm_wr = 1'($urandom);
        bus.dm_addr = 16'($urandom); bus.dm_wdata = 16'($urandom);
      end
      if (m_busy) begin
        if (just) begin
          cnt = $urandom_range(1, 4);
          bus.mem_done = 0;
        end else begin
          cnt--;
          bus.mem_done = (cnt == 0);
          bus.mem_rdata = 16'($urandom);
        end
      end else begin
        bus.mem_done = ($urandom_range(0, 7) == 0);
        bus.mem_rdata = 16'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
